// File: rtl/bin_lookup_ctrl.sv
// Keypad-to-BIN-lookup sequencer: collects six digits, fires one lookup start,
// waits for done/found under a timeout and holds the result for a valid/ack consumer.
module bin_lookup_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned CNT_W          = 13
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        clear,
    output logic        lk_start,
    output logic [23:0] lk_digits,
    input  logic        lk_done,
    input  logic        lk_found,
    output logic        result_valid,
    input  logic        result_ack,
    output logic [1:0]  result_status,
    output logic [2:0]  digit_count,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_COLLECT,
        S_START,
        S_WAIT_DONE,
        S_SETTLE,
        S_REPORT
    } state_t;

    localparam logic [1:0] ST_NONE    = 2'b00;
    localparam logic [1:0] ST_HIT     = 2'b01;
    localparam logic [1:0] ST_MISS    = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [23:0]        digits_d;
    logic [2:0]         count_d;
    logic [1:0]         status_d;
    logic               digit_ok;

    assign digit_ok = digit_valid && (digit <= 4'd9);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        digits_d = lk_digits;
        count_d  = digit_count;
        status_d = result_status;
        if (clear) begin
            state_d  = S_COLLECT;
            cnt_d    = '0;
            digits_d = '0;
            count_d  = '0;
            status_d = ST_NONE;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (digit_ok) begin
                        // First digit of a new entry replaces the previous query outright.
                        digits_d = (digit_count == 3'd0) ? {20'h0, digit}
                                                         : {lk_digits[19:0], digit};
                        count_d  = digit_count + 3'd1;
                        if (digit_count == 3'd5)
                            state_d = S_START;
                    end
                end
                S_START: begin
                    cnt_d   = '0;
                    state_d = S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    cnt_d = cnt_q + 1'b1;
                    if (lk_done) begin
                        if (lk_found) begin
                            state_d  = S_REPORT;
                            status_d = ST_HIT;
                        end else begin
                            cnt_d   = '0;
                            state_d = S_SETTLE;
                        end
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d  = S_REPORT;
                        status_d = ST_TIMEOUT;
                    end
                end
                S_SETTLE: begin
                    cnt_d = cnt_q + 1'b1;
                    if (lk_found) begin
                        state_d  = S_REPORT;
                        status_d = ST_HIT;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_d  = S_REPORT;
                        status_d = ST_MISS;
                    end
                end
                S_REPORT: begin
                    if (result_ack) begin
                        state_d  = S_COLLECT;
                        count_d  = '0;
                        status_d = ST_NONE;
                    end
                end
                default: state_d = S_COLLECT;
            endcase
        end
    end

    // Flag outputs are decoded from the next state so they stay registered.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_COLLECT;
            cnt_q         <= '0;
            lk_digits     <= '0;
            digit_count   <= '0;
            result_status <= ST_NONE;
            lk_start      <= 1'b0;
            result_valid  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lk_digits     <= digits_d;
            digit_count   <= count_d;
            result_status <= status_d;
            lk_start      <= (state_d == S_START);
            result_valid  <= (state_d == S_REPORT);
            busy          <= (state_d == S_START) || (state_d == S_WAIT_DONE)
                             || (state_d == S_SETTLE);
        end
    end

endmodule

// File: doc/bin_lookup_ctrl.md
# bin_lookup_ctrl

Sequencer between the keypad digit stream and the BIN lookup engine (`getBinInfo`). It collects six decimal digits and issues a single-cycle start to the lookup. It then waits for the engine's done/found, bounded by a timeout, and presents a latched result status to the display/UI logic through a valid/ack handshake. It is the only driver of the lookup engine's `start` and digit inputs.

## Interface

- `TIMEOUT_CYCLES`, 4096: max cycles in WAIT_DONE before declaring timeout.
- `SETTLE_CYCLES`, 16: max cycles after `lk_done` to wait for `lk_found` (sub-searches finish after the binary search).
- `CNT_W`, 13: width of the shared wait counter. Must hold max(TIMEOUT_CYCLES, SETTLE_CYCLES).

- `CLOCK_50`  in  1  system clock, all logic on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `digit_valid`  in  1  one-cycle strobe, new keypad digit.
- `digit`  in  4  BCD digit. Values >9 are ignored.
- `clear`  in  1  abort/clear entry, level-sampled each cycle.
- `lk_start`  out  1  one-cycle start pulse to lookup engine.
- `lk_digits`  out  24  {d5,d4,d3,d2,d1,d0}, d5 = first digit entered, in [23:20].
- `lk_done`  in  1  lookup engine binary search finished.
- `lk_found`  in  1  lookup engine full result (BIN + all fields) valid.
- `result_valid`  out  1  result status available.
- `result_ack`  in  1  consumer accepts result.
- `result_status`  out  2  00 none, 01 HIT, 10 MISS, 11 TIMEOUT.
- `digit_count`  out  3  digits collected so far (0–6).
- `busy`  out  1  high in START, WAIT_DONE, SETTLE.

## Operation

- States: COLLECT, START, WAIT_DONE, SETTLE, REPORT.
- COLLECT:
  - An accepted digit (`digit_valid` and `digit`<=9) shifts left into `lk_digits` (new digit into [3:0]) and increments `digit_count`.
  - On the 6th accepted digit, go to START.
- START:
  - `lk_start`=1 for exactly this cycle.
  - Clear the wait counter.
  - Go to WAIT_DONE.
- WAIT_DONE:
  - Counter increments each cycle.
  - `lk_done`=1 with `lk_found`=1: go to REPORT, status HIT.
  - `lk_done`=1 with `lk_found`=0: clear counter, go to SETTLE.
  - Counter reaches TIMEOUT_CYCLES-1 with no done: go to REPORT, status TIMEOUT.
- SETTLE:
  - `lk_found`=1: go to REPORT, HIT.
  - Counter reaches SETTLE_CYCLES-1 without found: go to REPORT, MISS.
- REPORT:
  - `result_valid`=1; `result_status` is held.
  - When `result_ack`=1: go to COLLECT, `digit_count`=0, `result_status`=00.
  - `lk_digits` keeps the last query until the next digit is accepted.
- Digits arriving outside COLLECT are dropped, with no effect.
- `clear`=1 in any state:
  - Next state COLLECT, `digit_count`=0, `lk_digits`=0, `result_valid`=0, `result_status`=00.
  - `clear` has priority over digits, done, found and ack in the same cycle.
  - A clear during WAIT_DONE/SETTLE abandons the query. Any later `lk_done`/`lk_found` is ignored because the state is COLLECT.
- `lk_done`/`lk_found` are sampled only in WAIT_DONE/SETTLE.

## Timing

- Reset values: state COLLECT, `lk_start`=0, `lk_digits`=0, `result_valid`=0, `result_status`=00, `digit_count`=0, `busy`=0, counter=0.
- All outputs are registered.
- 6th digit strobe at edge t: `lk_start` high in cycle t+1, and `lk_digits` is stable no later than that cycle. WAIT_DONE starts at t+2.
- `lk_done` is first sampled the cycle after `lk_start`.
- `lk_done`&`lk_found` sampled at cycle d: `result_valid` high from cycle d+1.
- Timeout: `result_valid` rises exactly TIMEOUT_CYCLES cycles after WAIT_DONE entry.
- MISS: `result_valid` rises SETTLE_CYCLES+1 cycles after the done cycle.
- `result_ack` sampled while `result_valid`=1: `result_valid` low the next cycle. A digit in that same ack cycle is dropped.
- An ack asserted while `result_valid`=0 has no effect.
- Reset asserted mid-query: immediate return to reset values; no `lk_start` is generated.

## Test plan

- Digits 4,5,1,0,3,2, with `lk_done`&`lk_found` arriving 20 cycles after `lk_start` → `lk_digits`=24'h451032, a single `lk_start` pulse, `result_status`=01 one cycle later, cleared to 00 after ack.
- Same entry, `lk_done` without found, `lk_found` 5 cycles later → HIT. Repeat with found never asserted → MISS exactly SETTLE_CYCLES+1 cycles after done.
- Same entry, `lk_done` never asserted, TIMEOUT_CYCLES=64 → status 11 at WAIT_DONE entry+64. A late `lk_done` afterwards is ignored.
- Digits 7, 12 (invalid), 3 → `digit_count`=2, `lk_digits`=24'h000073. Digit strobes during WAIT_DONE/REPORT → count unchanged.
- `clear` during WAIT_DONE, then `lk_done`/`lk_found` pulse → state COLLECT, `result_valid` stays 0. `clear` and `result_ack` in the same cycle → cleared state, no glitch.
- `resetn` low mid-SETTLE, then release → all outputs at reset values. A fresh 6-digit entry produces a normal lookup.
